mul_rep_add_seq: RTL and testbench
==================================

Name: mul_rep_add_seq

Overview:
Parametrised sequential multiplier that forms a product by repeated addition. It is the next generation of the team's datapath/controller multiplier.
- Both operands are captured in one cycle under a start/ready handshake.
- Supports signed (two's complement) and unsigned operands.
- Iterates over the smaller operand magnitude and exits early when either operand is zero.
- Used as a low-area multiplier where latency is not critical.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
SWAP_EN, 1, 1 = iteration count is the smaller operand magnitude; 0 = iteration count is always |b_in|.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
a_in  input  WIDTH  multiplicand, sampled on the accept edge
b_in  input  WIDTH  multiplier, sampled on the accept edge
signed_mode  input  1  1 = operands are two's complement; sampled on the accept edge
ready  output  1  high in IDLE only
busy  output  1  high in SETUP and ADD
done  output  1  one-cycle pulse; product is valid from this cycle on
product  output  2*WIDTH  registered result, held until the next accept

Behaviour:
- Reset (synchronous, rst=1 at an edge) from any state, including mid-operation: state=IDLE, product=0, done=0, busy=0, ready=1. All internal registers are cleared. The partial result is discarded.
- States: IDLE, SETUP, ADD, DONE.
- IDLE:
  - ready=1.
  - On start=1: capture a_in, b_in and signed_mode, then go to SETUP.
  - start=0 keeps IDLE.
- SETUP (1 cycle):
  - Form WIDTH-bit unsigned magnitudes: |x| when signed_mode=1 and the MSB is set, else x. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits.
  - neg = signed_mode & (a_msb ^ b_msb).
  - Either magnitude 0: product<=0, go to DONE.
  - Otherwise, with SWAP_EN=1: cnt<=min magnitude, addend<=max magnitude. Ties take cnt=|b|.
  - Otherwise, with SWAP_EN=0: cnt<=|b|, addend<=|a|.
  - In both non-zero cases: acc<=0, go to ADD.
- ADD:
  - Each cycle: acc<=acc+addend (2*WIDTH-bit add, zero-extended addend), cnt<=cnt-1.
  - When cnt==1 this is the last add: product<=neg ? -(acc+addend) : (acc+addend), go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE. product holds its value.
- Latency, counted in rising edges from the accept edge to the first cycle with done=1:
  - Non-zero operands: cnt_init+2 edges.
  - Either operand zero: 2 edges.
  - Throughput: one new start is accepted in the cycle after done.
- start while ready=0 is ignored with no side effect. a_in, b_in and signed_mode are don't-care outside the accept edge.
- No overflow is possible: all signed and unsigned products fit in 2*WIDTH bits, including (-2^(W-1))^2 = 2^(2W-2).
- product changes only on the edge that enters DONE (or on reset). It is never transiently wrong while done=0.
- cnt is WIDTH bits. Maximum iterations are 2^WIDTH-1 (unsigned, SWAP_EN=0); no wrap is possible because the exit is at cnt==1.

Decomposition:
- Shared package mul_rep_add_pkg: state enum (IDLE, SETUP, ADD, DONE) and default WIDTH constant.
- One sub-module: mul_rep_add_ctrl, the FSM.
  - Inputs: start, zero flag, last flag (cnt==1).
  - Outputs: load, setup, add and finish strobes, plus ready, busy and done.
- Top level holds the datapath: operand/magnitude registers, cnt, acc, product.

Test Plan:
1. Unsigned, W=16, a=17, b=5, SWAP_EN=1 -> product=85, done 7 edges after accept. Same with SWAP_EN=0 and a=5, b=17 -> product=85, done 19 edges after accept.
2. Signed: a=-3 (0xFFFD), b=7 -> product=0xFFFFFFEB (-21). Signed a=-32768, b=-32768 -> product=0x40000000. Unsigned a=0xFFFF, b=2 -> product=131070 in 4 edges.
3. Zero early-exit: a=0, b=1234 (either mode) -> product=0, done 2 edges after accept, no ADD cycles. b=0 gives the same result.
4. Handshake: pulse start with new operands every cycle while busy -> only the first operation is taken. ready=0 throughout. done is a single-cycle pulse. product is stable until the next accept.
5. Reset mid-operation: a=100, b=200; assert rst in the 10th ADD cycle -> next cycle product=0, done=0, ready=1. A subsequent 6x7 gives 42.
6. Back-to-back: start held high continuously with 9x9 then 3x4 -> second accept in the cycle after the first done. Products 81 then 12.

Source files
------------

// File: rtl/mul_rep_add_pkg.sv
// Shared definitions for the repeated-addition multiplier: controller states
// and the default operand width.
package mul_rep_add_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_rep_add_ctrl.sv
// Sequencing FSM for the repeated-addition multiplier.
//   state | meaning
//   IDLE  | ready for a request; start captures operands
//   SETUP | magnitudes, sign and loop count formed from captured operands
//   ADD   | one accumulate per cycle until the count reaches its last step
//   DONE  | one-cycle done pulse; product already valid
module mul_rep_add_ctrl
    import mul_rep_add_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic zero,
    input  logic last,
    output logic load,
    output logic setup,
    output logic add,
    output logic finish,
    output logic ready,
    output logic busy,
    output logic done
);

    state_t state;

    assign load   = (state == IDLE) & start;
    assign setup  = (state == SETUP);
    assign add    = (state == ADD);
    assign finish = add & last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SETUP;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (zero) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mul_rep_add_seq.sv
// Low-area sequential multiplier: forms |a|*|b| by repeated addition of the
// larger magnitude, then applies the sign on the last add.
module mul_rep_add_seq
    import mul_rep_add_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SWAP_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 signed_mode,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sm_q;
    logic               neg;
    logic [WIDTH-1:0]   cnt;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] sum;
    logic               zero;
    logic               last;
    logic               load;
    logic               setup;
    logic               add;
    logic               finish;

    // Unsigned WIDTH-bit magnitude; the most negative value maps to 2^(WIDTH-1).
    assign mag_a = (sm_q & a_q[WIDTH-1]) ? (WIDTH'(0) - a_q) : a_q;
    assign mag_b = (sm_q & b_q[WIDTH-1]) ? (WIDTH'(0) - b_q) : b_q;
    assign zero  = (mag_a == '0) | (mag_b == '0);
    assign last  = (cnt == WIDTH'(1));
    assign sum   = acc + {{WIDTH{1'b0}}, addend};

    mul_rep_add_ctrl u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .zero   (zero),
        .last   (last),
        .load   (load),
        .setup  (setup),
        .add    (add),
        .finish (finish),
        .ready  (ready),
        .busy   (busy),
        .done   (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            neg     <= 1'b0;
            cnt     <= '0;
            addend  <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            if (load) begin
                a_q  <= a_in;
                b_q  <= b_in;
                sm_q <= signed_mode;
            end
            if (setup) begin
                neg <= sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                if (zero) begin
                    product <= '0;
                end else begin
                    acc <= '0;
                    // Loop over the smaller magnitude; a tie keeps |b| as the count.
                    if ((SWAP_EN != 0) && (mag_a < mag_b)) begin
                        cnt    <= mag_a;
                        addend <= mag_b;
                    end else begin
                        cnt    <= mag_b;
                        addend <= mag_a;
                    end
                end
            end
            if (add) begin
                acc <= sum;
                cnt <= cnt - WIDTH'(1);
            end
            if (finish) begin
                product <= neg ? (-sum) : sum;
            end
        end
    end

endmodule

// File: tb/tb_mul_rep_add_seq.sv
// Directed bench for mul_rep_add_seq: one instance with operand swapping, one without,
// checked each cycle against an arithmetic reference model.
module tb_mul_rep_add_seq;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start_v [2];
    logic [W-1:0]   a_v     [2];
    logic [W-1:0]   b_v     [2];
    logic           sm_v    [2];
    logic           ready_v [2];
    logic           busy_v  [2];
    logic           done_v  [2];
    logic [2*W-1:0] prod_v  [2];

    mul_rep_add_seq #(.WIDTH(W), .SWAP_EN(1)) u_swap (
        .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
        .signed_mode(sm_v[0]), .ready(ready_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .product(prod_v[0])
    );

    mul_rep_add_seq #(.WIDTH(W), .SWAP_EN(0)) u_noswap (
        .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
        .signed_mode(sm_v[1]), .ready(ready_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .product(prod_v[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus-side state
    logic [31:0] lit_p [2];
    int          lit_l [2];
    int          timeouts = 0;
    bit          fin = 1'b0;

    // Monitor-side state
    int          total = 0;
    int          bad = 0;
    bit          pend    [2];
    int          acc_cyc [2];
    int          lat     [2];
    logic [31:0] exp_p   [2];
    logic [31:0] held_p  [2];
    logic [31:0] lit_pq  [2];
    int          lit_lq  [2];

    // Reference: signed/unsigned product by plain multiplication; latency from loop count.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sm, input bit swap,
                                  output logic [31:0] p, output int l);
        longint av, bv, ma, mb, pr, c;
        av = (sm && a[W-1]) ? longint'(a) - 65536 : longint'(a);
        bv = (sm && b[W-1]) ? longint'(b) - 65536 : longint'(b);
        pr = av * bv;
        p  = pr[31:0];
        ma = (av < 0) ? -av : av;
        mb = (bv < 0) ? -bv : bv;
        c  = (swap && ma < mb) ? ma : mb;
        l  = (ma == 0 || mb == 0) ? 2 : int'(c) + 2;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] cyc=%0d: got %0h want %0h", name, g, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fin) begin
            chk("timeouts", 0, 32'(timeouts), 32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (cyc >= 1) begin
            for (int g = 0; g < 2; g++) begin
                int   dcyc;
                bit   was_pend;
                logic e_done;
                was_pend = pend[g];
                dcyc     = acc_cyc[g] + lat[g];
                e_done   = was_pend && (cyc == dcyc);
                if (e_done) held_p[g] = exp_p[g];
                chk("done",    g, 32'(done_v[g]),  32'(e_done));
                chk("ready",   g, 32'(ready_v[g]), 32'(!was_pend));
                chk("busy",    g, 32'(busy_v[g]),  32'(was_pend && cyc < dcyc));
                chk("product", g, prod_v[g],       held_p[g]);
                if (e_done) begin
                    chk("model_lit_product", g, exp_p[g],    lit_pq[g]);
                    chk("model_lit_latency", g, 32'(lat[g]), 32'(lit_lq[g]));
                    pend[g] = 1'b0;
                end
                if (rst) begin
                    pend[g]   = 1'b0;
                    held_p[g] = '0;
                end else if (!was_pend && start_v[g]) begin
                    pend[g]    = 1'b1;
                    acc_cyc[g] = cyc;
                    model(a_v[g], b_v[g], sm_v[g], (g == 0), exp_p[g], lat[g]);
                    lit_pq[g]  = lit_p[g];
                    lit_lq[g]  = lit_l[g];
                end
            end
        end
    end

    task automatic wait_ready(input int g);
        int n = 0;
        while (!ready_v[g] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_v[g]) timeouts++;
    endtask

    task automatic wait_done(input int g);
        int n = 0;
        while (!done_v[g] && n < 40000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done_v[g]) timeouts++;
    endtask

    task automatic drive(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic [31:0] lp, input int ll);
        a_v[g]   = a;
        b_v[g]   = b;
        sm_v[g]  = sm;
        lit_p[g] = lp;
        lit_l[g] = ll;
    endtask

    task automatic run_op(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sm, input logic [31:0] lp, input int ll);
        wait_ready(g);
        drive(g, a, b, sm, lp, ll);
        start_v[g] = 1'b1;
        @(posedge clk); #1;
        start_v[g] = 1'b0;
        wait_done(g);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start_v[g] = 1'b0;
            drive(g, '0, '0, 1'b0, '0, 0);
            pend[g]    = 1'b0;
            acc_cyc[g] = 0;
            lat[g]     = 0;
            exp_p[g]   = '0;
            held_p[g]  = '0;
            lit_pq[g]  = '0;
            lit_lq[g]  = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic unsigned, with and without swapping
        run_op(0, 16'd17, 16'd5, 1'b0, 32'd85, 7);
        run_op(1, 16'd5, 16'd17, 1'b0, 32'd85, 19);

        // Signed and unsigned extremes
        run_op(0, 16'hFFFD, 16'd7, 1'b1, 32'hFFFF_FFEB, 5);
        run_op(0, 16'd7, 16'hFFF7, 1'b1, 32'hFFFF_FFC1, 9);
        run_op(1, 16'hFFFB, 16'd3, 1'b1, 32'hFFFF_FFF1, 5);
        run_op(0, 16'hFFFF, 16'd2, 1'b0, 32'd131070, 4);
        run_op(0, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 32770);

        // Zero early exit
        run_op(0, 16'd0, 16'd1234, 1'b0, 32'd0, 2);
        run_op(1, 16'd0, 16'd1234, 1'b1, 32'd0, 2);
        run_op(0, 16'd1234, 16'd0, 1'b0, 32'd0, 2);

        // Start pulses with fresh operands while busy must be ignored
        wait_ready(0);
        drive(0, 16'd17, 16'd5, 1'b0, 32'd85, 7);
        start_v[0] = 1'b1;
        for (int n = 0; n < 40 && !done_v[0]; n++) begin
            @(posedge clk); #1;
            if (!done_v[0]) begin
                a_v[0]  = W'($urandom_range(1, 65535));
                b_v[0]  = W'($urandom_range(1, 65535));
                sm_v[0] = 1'($urandom_range(0, 1));
            end
        end
        if (!done_v[0]) timeouts++;
        start_v[0] = 1'b0;
        @(posedge clk); #1;

        // Reset during the 10th ADD cycle, then a fresh operation
        wait_ready(0);
        drive(0, 16'd100, 16'd200, 1'b0, 32'd20000, 102);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(0, 16'd6, 16'd7, 1'b0, 32'd42, 8);

        // Back-to-back with start held high
        wait_ready(0);
        drive(0, 16'd9, 16'd9, 1'b0, 32'd81, 11);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        wait_done(0);
        drive(0, 16'd3, 16'd4, 1'b0, 32'd12, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1 fin = 1'b1;
    end

endmodule
